// File: rtl/axi4_burst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_seq_pkg
// Purpose  : Shared types and AXI constants for the burst sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_burst_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    // Number of low address bits covered by one full burst.
    function automatic int align_bits(input int len, input int data_w);
        return $clog2(len * data_w / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_burst_seq_pattern.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_seq_pattern
// Purpose  : Beat counter and seed+k generator shared by the write and read phases.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_seq_pattern #(
    parameter int DATA_W = 32,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_seed,
    input  logic              advance,
    output logic [DATA_W-1:0] value,
    output logic              last
);

    localparam int              CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    logic [DATA_W-1:0] base;
    logic [CNT_W-1:0]  idx;

    // The counter wraps after the last beat so the read phase restarts at k = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            idx  <= '0;
        end else if (load) begin
            base <= load_seed;
            idx  <= '0;
        end else if (advance) begin
            idx  <= last ? '0 : idx + 1'b1;
        end
    end

    assign last  = (idx == LAST_IDX);
    assign value = base + DATA_W'(idx);

endmodule
`default_nettype wire

// File: rtl/axi4_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_seq
// Purpose  : Writes one INCR burst of seed+k, reads it back and counts errors.
//            AXI4_BURST_SEQ_LOOP_EN adds loop_stop and auto-restarting iterations.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_seq
    import axi4_burst_seq_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_BURST_LEN  = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   base_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
`ifdef AXI4_BURST_SEQ_LOOP_EN
    input  logic                            loop_stop,
`endif
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [7:0]                      err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int DW  = C_M_AXI_DATA_WIDTH;
    localparam int LEN = C_M_AXI_BURST_LEN;
    localparam int ALIGN_W = align_bits(LEN, DW);
    localparam logic [AW-1:0] ALIGN_MASK = ~((AW'(1) << ALIGN_W) - AW'(1));

    state_t            state, state_nx;
    logic [AW-1:0]     addr;
    logic              pass_q;
    logic              pat_load, pat_advance, pat_last;
    logic [DW-1:0]     pat_value, pat_seed;
    logic [1:0]        err_inc;
    logic [8:0]        err_sum;

`ifdef AXI4_BURST_SEQ_LOOP_EN
    localparam logic [AW-1:0] PAGE_MASK = AW'(12'hFFF);
    localparam logic [AW-1:0] STEP      = AW'(LEN * DW / 8);
    logic          loop_again, stop_seen, stop_now;
    logic [AW-1:0] next_addr;

    assign stop_now  = stop_seen | loop_stop;
    assign next_addr = (addr & ~PAGE_MASK) | ((addr + STEP) & PAGE_MASK);
    // In FIN the counter has wrapped, so pat_value equals the current seed.
    assign pat_seed  = loop_again ? pat_value + DW'(LEN) : seed;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            stop_seen <= 1'b0;
        else if (state == S_IDLE)
            stop_seen <= 1'b0;
        else if (loop_stop)
            stop_seen <= 1'b1;
    end
`else
    assign pat_seed = seed;
`endif

    axi4_burst_seq_pattern #(
        .DATA_W (DW),
        .LEN    (LEN)
    ) u_pattern (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .load      (pat_load),
        .load_seed (pat_seed),
        .advance   (pat_advance),
        .value     (pat_value),
        .last      (pat_last)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        pat_load    = 1'b0;
        pat_advance = 1'b0;
`ifdef AXI4_BURST_SEQ_LOOP_EN
        loop_again  = 1'b0;
`endif
        case (state)
            S_IDLE: if (start) begin
                state_nx = S_AW;
                pat_load = 1'b1;
            end
            S_AW:   if (M_AXI_AWREADY) state_nx = S_W;
            S_W:    if (M_AXI_WREADY) begin
                pat_advance = 1'b1;
                if (pat_last) state_nx = S_B;
            end
            S_B:    if (M_AXI_BVALID) state_nx = S_AR;
            S_AR:   if (M_AXI_ARREADY) state_nx = S_R;
            S_R:    if (M_AXI_RVALID) begin
                pat_advance = 1'b1;
                if (pat_last) state_nx = S_FIN;
            end
            S_FIN: begin
                state_nx = S_IDLE;
`ifdef AXI4_BURST_SEQ_LOOP_EN
                if (!stop_now && err_count == 8'd0) begin
                    state_nx   = S_AW;
                    pat_load   = 1'b1;
                    loop_again = 1'b1;
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A single read beat can carry up to three independent faults.
    always_comb begin
        err_inc = 2'd0;
        if (state == S_B && M_AXI_BVALID && M_AXI_BRESP != RESP_OKAY)
            err_inc = 2'd1;
        else if (state == S_R && M_AXI_RVALID)
            err_inc = 2'(M_AXI_RDATA != pat_value) +
                      2'(M_AXI_RRESP != RESP_OKAY) +
                      2'(M_AXI_RLAST != pat_last);
    end

    assign err_sum = {1'b0, err_count} + 9'(err_inc);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr      <= '0;
            err_count <= 8'd0;
            pass_q    <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                addr      <= base_addr & ALIGN_MASK;
                err_count <= 8'd0;
                pass_q    <= 1'b0;
`ifdef AXI4_BURST_SEQ_LOOP_EN
            end else if (loop_again) begin
                addr      <= next_addr;
                err_count <= 8'd0;
`endif
            end else if (err_inc != 2'd0) begin
                err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
            end
            if (state == S_FIN)
                pass_q <= (err_count == 8'd0);
        end
    end

    assign busy = (state != S_IDLE) && (state != S_FIN);
    assign done = (state == S_FIN);
    assign pass = (state == S_FIN) ? (err_count == 8'd0) : pass_q;

    assign M_AXI_AWADDR  = addr;
    assign M_AXI_AWLEN   = 8'(LEN - 1);
    assign M_AXI_AWSIZE  = axsize(DW);
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = (state == S_AW);
    assign M_AXI_WDATA   = pat_value;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (state == S_W) && pat_last;
    assign M_AXI_WVALID  = (state == S_W);
    assign M_AXI_BREADY  = (state == S_B);
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = 8'(LEN - 1);
    assign M_AXI_ARSIZE  = axsize(DW);
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARVALID = (state == S_AR);
    assign M_AXI_RREADY  = (state == S_R);

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_burst_seq
// Purpose  : Directed bench with a memory slave model for axi4_burst_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_seq;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LEN = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] seed = '0;
`ifdef AXI4_BURST_SEQ_LOOP_EN
    logic          loop_stop = 1'b0;
`endif
    logic          busy, done, pass;
    logic [7:0]    err_count;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [7:0]    M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]    M_AXI_AWSIZE, M_AXI_ARSIZE;
    logic [1:0]    M_AXI_AWBURST, M_AXI_ARBURST;
    logic          M_AXI_AWVALID, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY;
    logic          M_AXI_ARVALID, M_AXI_RREADY;
    logic [DW-1:0] M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;

    // Slave model state
    logic          awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]    bresp;
    logic [1:0]    rresp = 2'b00;
    logic [DW-1:0] rdata;
    logic [DW-1:0] mem [0:255];
    logic [AW-1:0] waddr, raddr;
    int            wcount = 0, aw_count = 0, r_left = 0, r_idx = 0, wlast_err = 0;
    logic          b_pend;
    logic [DW-1:0] wlog [0:15];
    logic [DW-1:0] firstlog [0:15];
    logic [AW-1:0] awlog [0:15];
    logic [AW-1:0] araddr_last;

    // Knobs set by the stimulus
    bit            stall_en = 1'b0;
    int            corrupt_idx = -1;
    logic [1:0]    bresp_cfg = 2'b00;
    bit            drop_rlast = 1'b0;

    int            stab_err = 0;
    int            errors = 0, checks = 0;

    always #5 ACLK = ~ACLK;

    axi4_burst_seq #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_M_AXI_BURST_LEN  (LEN)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .base_addr     (base_addr),
        .seed          (seed),
`ifdef AXI4_BURST_SEQ_LOOP_EN
        .loop_stop     (loop_stop),
`endif
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    function automatic logic rnd_ready();
        return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Memory slave with optional random stalls and fault injection.
    always @(posedge ACLK) begin
        if (!ARESETN) begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            bvalid  <= 1'b0; bresp  <= 2'b00; b_pend <= 1'b0;
            rvalid  <= 1'b0; rlast  <= 1'b0; rdata  <= '0;
            r_left  <= 0;
        end else begin
            awready <= rnd_ready();
            wready  <= rnd_ready();
            arready <= rnd_ready();
            if (M_AXI_AWVALID && awready) begin
                waddr    <= M_AXI_AWADDR;
                wcount   <= 0;
                awlog[aw_count & 15] <= M_AXI_AWADDR;
                aw_count <= aw_count + 1;
            end
            if (M_AXI_WVALID && wready) begin
                mem[((waddr >> 2) + wcount) & 255] <= M_AXI_WDATA;
                wlog[wcount & 15] <= M_AXI_WDATA;
                if (wcount == 0) firstlog[(aw_count - 1) & 15] <= M_AXI_WDATA;
                if (M_AXI_WLAST != (wcount == LEN - 1)) wlast_err <= wlast_err + 1;
                if (wcount == LEN - 1) b_pend <= 1'b1;
                wcount <= wcount + 1;
            end
            if (bvalid && M_AXI_BREADY) begin
                bvalid <= 1'b0;
            end else if (b_pend && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= bresp_cfg;
                b_pend <= 1'b0;
            end
            if (M_AXI_ARVALID && arready) begin
                raddr       <= M_AXI_ARADDR;
                araddr_last <= M_AXI_ARADDR;
                r_left      <= LEN;
                r_idx       <= 0;
            end
            if (r_left > 0 && (!rvalid || M_AXI_RREADY) && rnd_ready()) begin
                rvalid <= 1'b1;
                rdata  <= mem[((raddr >> 2) + r_idx) & 255] ^ ((r_idx == corrupt_idx) ? 32'h1 : 32'h0);
                rlast  <= (r_idx == LEN - 1) && !drop_rlast;
                r_idx  <= r_idx + 1;
                r_left <= r_left - 1;
            end else if (rvalid && M_AXI_RREADY) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

    // VALID must stay high with stable payload until its handshake.
    logic          p_aw, p_w, p_ar;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic          p_wlast;
    always @(posedge ACLK) begin
        if (!ARESETN) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
        end else begin
            if (p_aw && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awaddr)) stab_err <= stab_err + 1;
            if (p_w && (!M_AXI_WVALID || M_AXI_WDATA != p_wdata || M_AXI_WLAST != p_wlast)) stab_err <= stab_err + 1;
            if (p_ar && (!M_AXI_ARVALID || M_AXI_ARADDR != p_araddr)) stab_err <= stab_err + 1;
            p_aw <= M_AXI_AWVALID && !awready; p_awaddr <= M_AXI_AWADDR;
            p_w  <= M_AXI_WVALID && !wready;   p_wdata  <= M_AXI_WDATA; p_wlast <= M_AXI_WLAST;
            p_ar <= M_AXI_ARVALID && !arready; p_araddr <= M_AXI_ARADDR;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, optionally re-pulse it mid-sequence, and wait for done.
    task automatic run_seq(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] s,
                           input bit poke);
        int cyc;
        @(negedge ACLK);
        base_addr = a; seed = s; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        check({tag, "_awvalid_rise"}, 64'(M_AXI_AWVALID), 64'd1);
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge ACLK);
            cyc++;
            start = (poke && cyc == 3);
            if (poke && cyc == 3) seed = 32'h99;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_busy_in_fin"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int a0, nd, cyc;

        // Reset values
        repeat (3) @(negedge ACLK);
        check("rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
        check("rst_wvalid",  64'(M_AXI_WVALID), 64'd0);
        check("rst_wlast",   64'(M_AXI_WLAST), 64'd0);
        check("rst_bready",  64'(M_AXI_BREADY), 64'd0);
        check("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        check("rst_rready",  64'(M_AXI_RREADY), 64'd0);
        check("rst_awaddr",  64'(M_AXI_AWADDR), 64'd0);
        check("rst_wdata",   64'(M_AXI_WDATA), 64'd0);
        check("rst_flags",   64'({busy, done, pass}), 64'd0);
        check("rst_errcnt",  64'(err_count), 64'd0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("burst_fields", 64'({M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_WSTRB}),
              64'({8'd7, 3'd2, 2'b01, 4'hF}));

        // Zero-wait, base 0, seed 1, with a dropped start mid-sequence
        a0 = aw_count;
        run_seq("t1", 32'h0, 32'h1, 1'b1);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_err",  64'(err_count), 64'd0);
        @(negedge ACLK);
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_pass_held",  64'(pass), 64'd1);
        for (int k = 0; k < LEN; k++) check($sformatf("t1_wdata%0d", k), 64'(wlog[k]), 64'(k + 1));
        check("t1_wlast",   64'(wlast_err), 64'd0);
        check("t1_awaddr",  64'(awlog[a0 & 15]), 64'h0);
        check("t1_one_aw",  64'(aw_count - a0), 64'd1);
        check("t1_stable",  64'(stab_err), 64'd0);

        // Random stalls, unaligned base, seed wrapping through zero
        stall_en = 1'b1;
        a0 = aw_count;
        run_seq("t2", 32'h47, 32'hFFFF_FFFC, 1'b0);
        check("t2_pass",   64'(pass), 64'd1);
        check("t2_err",    64'(err_count), 64'd0);
        check("t2_wdata3", 64'(wlog[3]), 64'hFFFF_FFFF);
        check("t2_wdata4", 64'(wlog[4]), 64'h0);
        check("t2_awaddr", 64'(awlog[a0 & 15]), 64'h40);
        check("t2_araddr", 64'(araddr_last), 64'h40);
        check("t2_stable", 64'(stab_err), 64'd0);
        check("t2_wlast",  64'(wlast_err), 64'd0);
        stall_en = 1'b0;

        // Corrupted read beat 3
        corrupt_idx = 3;
        run_seq("t3", 32'h20, 32'h10, 1'b0);
        check("t3_err",  64'(err_count), 64'd1);
        check("t3_pass", 64'(pass), 64'd0);
        @(negedge ACLK);
        check("t3_pass_held", 64'(pass), 64'd0);
        corrupt_idx = -1;

        // SLVERR write response plus missing RLAST
        bresp_cfg = 2'b10; drop_rlast = 1'b1;
        run_seq("t4", 32'h0, 32'h5, 1'b0);
        check("t4_err",  64'(err_count), 64'd2);
        check("t4_pass", 64'(pass), 64'd0);
        bresp_cfg = 2'b00; drop_rlast = 1'b0;

        // Asynchronous reset during write beat 4, then a clean run
        @(negedge ACLK);
        base_addr = 32'h0; seed = 32'h30; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        cyc = 0;
        while (!(M_AXI_WVALID && wcount == 4) && cyc < 200) begin
            @(negedge ACLK);
            cyc++;
        end
        check("t5_reached_beat4", 64'(M_AXI_WVALID && wcount == 4), 64'd1);
        #2 ARESETN = 1'b0;
        #1;
        check("t5_rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
        check("t5_rst_busy",   64'(busy), 64'd0);
        check("t5_rst_awaddr", 64'(M_AXI_AWADDR), 64'd0);
        check("t5_rst_wdata",  64'(M_AXI_WDATA), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("t5_idle_after", 64'({busy, M_AXI_AWVALID, M_AXI_WVALID}), 64'd0);
        run_seq("t5", 32'h60, 32'h5, 1'b0);
        check("t5_pass",   64'(pass), 64'd1);
        check("t5_err",    64'(err_count), 64'd0);
        check("t5_wdata7", 64'(wlog[7]), 64'hC);

`ifdef AXI4_BURST_SEQ_LOOP_EN
        // Three looping iterations, stopped during the third
        a0 = aw_count; nd = 0; cyc = 0;
        @(negedge ACLK);
        base_addr = 32'h0; seed = 32'h1; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        while (nd < 3 && cyc < 6000) begin
            @(negedge ACLK);
            cyc++;
            if (done) nd++;
            else if (nd == 2) loop_stop = 1'b1;
        end
        check("loop_pass", 64'(pass), 64'd1);
        repeat (20) begin
            @(negedge ACLK);
            if (done) nd++;
        end
        loop_stop = 1'b0;
        check("loop_dones", 64'(nd), 64'd3);
        check("loop_aws",   64'(aw_count - a0), 64'd3);
        check("loop_busy",  64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("loop_addr%0d", i), 64'(awlog[(a0 + i) & 15]), 64'(i * 32));
            check($sformatf("loop_seed%0d", i), 64'(firstlog[(a0 + i) & 15]), 64'(1 + i * 8));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_burst_seq.md
# axi4_burst_seq

Self-checking AXI4-full burst sequencer.
- On a `start` pulse it drives one INCR write burst of a counting pattern to an AXI4-full slave, then one read burst from the same address, and compares every returned beat.
- It reports pass/fail and an error count.
- It replaces the simulation-only write-then-read check with synthesizable hardware, so the slave under test can be exercised on silicon from a PS register or a button.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, address width
- `C_M_AXI_DATA_WIDTH`, 32, data width (32 or 64)
- `C_M_AXI_BURST_LEN`, 8, beats per burst (1..256)
- `ACLK  in  1  clock`
- `ARESETN  in  1  asynchronous active-low reset`
- `start  in  1  one-cycle request, ignored while busy`
- `base_addr  in  ADDR_W  burst start address, low log2(LEN*DATA_W/8) bits forced to 0`
- `seed  in  DATA_W  value of beat 0`
- `busy  out  1  sequence in progress`
- `done  out  1  one-cycle pulse at end of sequence`
- `pass  out  1  last sequence error-free, held until next start`
- `err_count  out  8  errors in last sequence, saturating at 255`
- `M_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out`; `M_AXI_AWREADY  in`
- `M_AXI_WDATA/WSTRB/WLAST/WVALID  out`; `M_AXI_WREADY  in`
- `M_AXI_BRESP  in  2`; `M_AXI_BVALID  in`; `M_AXI_BREADY  out`
- `M_AXI_ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out`; `M_AXI_ARREADY  in`
- `M_AXI_RDATA/RRESP/RLAST/RVALID  in`; `M_AXI_RREADY  out`

## Operation
- FSM states: IDLE → AW → W → B → AR → R → FIN → IDLE.
- **IDLE**: `start` latches the aligned `base_addr` and `seed`, and clears `err_count`.
- Burst fields, constant: AxLEN = LEN−1, AxSIZE = log2(DATA_W/8), AxBURST = INCR (2'b01), WSTRB all ones.
- **AW**: AWVALID is held until AWREADY. The state then moves to W.
- **W**:
  - Beat k: WDATA = seed + k, modulo 2^DATA_W.
  - WVALID is held high; the beat counter advances on WVALID & WREADY.
  - WLAST is high on beat LEN−1.
  - The last handshake moves the state to B.
- **B**: BREADY = 1. On BVALID the state moves to AR; a BRESP other than OKAY is one error.
- **AR**: ARVALID is held until ARREADY. The state then moves to R.
- **R**:
  - RREADY = 1. Each RVALID beat k is checked against seed + k.
  - One error is counted for each of these on a beat: data mismatch, RRESP ≠ OKAY, RLAST asserted before beat LEN−1, RLAST missing on beat LEN−1.
  - The beat with index LEN−1 ends the state, whatever RLAST is.
- **FIN**: `done` = 1 for one cycle; `pass` = (err_count == 0); the state returns to IDLE.
- Errors from the B and R states add to `err_count`, with saturation.

## Timing
- Reset values: all VALID/READY/LAST outputs 0, address/data outputs 0, busy = 0, done = 0, pass = 0, err_count = 0.
- Reset clears the FSM asynchronously at any time, including mid-burst. VALIDs drop immediately and no transaction is resumed.
- AWVALID rises the cycle after `start` is sampled. `busy` rises in the same cycle and falls in the FIN cycle.
- A VALID never deasserts before its handshake. Address and data are stable while VALID is high.
- Zero-wait slave throughput: one W beat per cycle and one R beat per cycle.
- `start` arriving during FIN or any busy state is dropped.

## Configuration
- `AXI4_BURST_SEQ_LOOP_EN`
  - **Defined**: port `loop_stop` (in, 1) is added. After FIN the sequence restarts automatically with seed += LEN and address += LEN·DATA_W/8, wrapping within the aligned 4 KB page. `done` and `pass` update every iteration. Looping ends at the first FIN after `loop_stop` is seen high, or at the first failing iteration.
  - **Undefined**: the port does not exist and each `start` produces a single sequence.

## Structure
- Package `axi4_burst_seq_pkg`:
  - state enum
  - BURST_INCR and RESP_OKAY constants
  - `clog2`-based SIZE/alignment helper constants
- Sub-module `axi4_burst_seq_pattern`: beat counter plus seed+k generator, shared by the W and R states, with a `last` output at k = LEN−1.

## Test plan
- **Zero-wait memory model, LEN = 8, base 0x0, seed 1**: W data 1..8, read back matches, done pulse, pass = 1, err_count = 0.
- **Random AWREADY/WREADY/ARREADY/RVALID stalls (50%)**: VALIDs stay stable under stall; the same pass result is produced.
- **Slave corrupts R beat 3 (XOR 0x1)**: err_count = 1, pass = 0.
- **Slave returns BRESP = SLVERR and drops RLAST on the final beat**: err_count = 2.
- **ARESETN low during W beat 4, then a new start**: outputs return to their reset values immediately, and a full clean sequence then passes.
- **LOOP_EN, 3 iterations then loop_stop**: seeds 1, 9, 17 and addresses 0x00, 0x20, 0x40 are seen, with 3 done pulses.
